// File: rtl/obi_periph_arbiter.sv
// ============================================================================
// Module      : obi_periph_arbiter
// Description : Two-initiator to one-target OBI arbiter with round-robin
//               selection and at most one transaction outstanding. The
//               A-channel of the owning initiator is forwarded to the target
//               and the single response is routed back to the owner.
//               Optional response watchdog: define OBI_ARB_TIMEOUT_EN to
//               build it in (TIMEOUT_CYCLES sets the limit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_periph_arbiter #(
  parameter int OBI_AW         = 32,
  parameter int OBI_DW         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // initiator side
  input  logic [1:0]              init_req,
  input  logic [2*OBI_AW-1:0]     init_addr,
  input  logic [1:0]              init_we,
  input  logic [2*OBI_DW/8-1:0]   init_be,
  input  logic [2*OBI_DW-1:0]     init_wdata,
  output logic [1:0]              init_gnt,
  output logic [1:0]              init_rvalid,
  output logic [OBI_DW-1:0]       init_rdata,
  output logic                    init_err,
  // target side
  output logic                    tgt_req,
  output logic [OBI_AW-1:0]       tgt_addr,
  output logic                    tgt_we,
  output logic [OBI_DW/8-1:0]     tgt_be,
  output logic [OBI_DW-1:0]       tgt_wdata,
  input  logic                    tgt_gnt,
  input  logic                    tgt_rvalid,
  input  logic [OBI_DW-1:0]       tgt_rdata,
  input  logic                    tgt_err
);

  localparam int BE_W = OBI_DW / 8;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_addr = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;

  logic              w_winner;
  logic              w_owner_req;
  logic [OBI_AW-1:0] w_own_addr;
  logic              w_own_we;
  logic [BE_W-1:0]   w_own_be;
  logic [OBI_DW-1:0] w_own_wdata;
  logic [1:0]        w_owner_onehot;
  logic              w_addr_done;
  logic              w_timeout;

  // A lone requester wins; on a tie the initiator not served last wins.
  assign w_winner = (init_req == 2'b11) ? ~last_grant_q : init_req[1];

  // Owner's A-channel slice.
  assign w_owner_req    = owner_q ? init_req[1] : init_req[0];
  assign w_own_addr     = owner_q ? init_addr[OBI_AW +: OBI_AW] : init_addr[0 +: OBI_AW];
  assign w_own_we       = owner_q ? init_we[1] : init_we[0];
  assign w_own_be       = owner_q ? init_be[BE_W +: BE_W] : init_be[0 +: BE_W];
  assign w_own_wdata    = owner_q ? init_wdata[OBI_DW +: OBI_DW] : init_wdata[0 +: OBI_DW];
  assign w_owner_onehot = owner_q ? 2'b10 : 2'b01;

  // Address phase completes on the target handshake.
  assign w_addr_done = (state_q == c_st_addr) && w_owner_req && tgt_gnt;

`ifdef OBI_ARB_TIMEOUT_EN
  localparam int              c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES);

  logic [c_cnt_w-1:0] tmo_cnt_q, tmo_cnt_d;

  // A real response in the limit cycle wins over the watchdog.
  assign w_timeout = (state_q == c_st_resp) && !tgt_rvalid && (tmo_cnt_q == c_cnt_max);

  // Watchdog count: cleared on entering RESP, one step per silent RESP cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (w_addr_done) begin
      tmo_cnt_d = '0;
    end else if ((state_q == c_st_resp) && !tgt_rvalid && !w_timeout) begin
      tmo_cnt_d = tmo_cnt_q + c_cnt_w'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Without the watchdog a response phase waits for the target forever.
  assign w_timeout = 1'b0;

  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State, owner and round-robin history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= c_st_idle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic: arbitrate, hand off address, wait for the response.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      c_st_idle: begin
        if (|init_req) begin
          owner_d = w_winner;
          state_d = c_st_addr;
        end
      end
      c_st_addr: begin
        if (w_addr_done) begin
          last_grant_d = owner_q;
          state_d      = c_st_resp;
        end else if (!w_owner_req) begin
          // Request withdrawn before grant: abandon silently.
          state_d = c_st_idle;
        end
      end
      c_st_resp: begin
        if (tgt_rvalid || w_timeout) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // Output logic: everything is zero unless the current phase drives it.
  always_comb begin
    tgt_req     = 1'b0;
    tgt_addr    = '0;
    tgt_we      = 1'b0;
    tgt_be      = '0;
    tgt_wdata   = '0;
    init_gnt    = 2'b00;
    init_rvalid = 2'b00;
    init_rdata  = '0;
    init_err    = 1'b0;
    case (state_q)
      c_st_addr: begin
        tgt_req   = w_owner_req;
        tgt_addr  = w_own_addr;
        tgt_we    = w_own_we;
        tgt_be    = w_own_be;
        tgt_wdata = w_own_wdata;
        init_gnt  = tgt_gnt ? w_owner_onehot : 2'b00;
      end
      c_st_resp: begin
        if (tgt_rvalid) begin
          init_rvalid = w_owner_onehot;
          init_rdata  = tgt_rdata;
          init_err    = tgt_err;
        end else if (w_timeout) begin
          init_rvalid = w_owner_onehot;
          init_err    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_periph_arbiter.sv
// ============================================================================
// Module      : tb_obi_periph_arbiter
// Description : Scoreboard bench for obi_periph_arbiter. A reference model
//               follows the arbitration/phase rules from the pins the bench
//               drives and queues expected grants and responses; a monitor
//               pops and compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_periph_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 4;

  localparam int PH_FREE = 0;
  localparam int PH_ADDR = 1;
  localparam int PH_RESP = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      init_req;
  logic [2*AW-1:0] init_addr;
  logic [1:0]      init_we;
  logic [2*BW-1:0] init_be;
  logic [2*DW-1:0] init_wdata;
  logic [1:0]      init_gnt;
  logic [1:0]      init_rvalid;
  logic [DW-1:0]   init_rdata;
  logic            init_err;
  logic            tgt_req;
  logic [AW-1:0]   tgt_addr;
  logic            tgt_we;
  logic [BW-1:0]   tgt_be;
  logic [DW-1:0]   tgt_wdata;
  logic            tgt_gnt;
  logic            tgt_rvalid;
  logic [DW-1:0]   tgt_rdata;
  logic            tgt_err;

  obi_periph_arbiter #(
    .OBI_AW(AW), .OBI_DW(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .init_req(init_req), .init_addr(init_addr), .init_we(init_we),
    .init_be(init_be), .init_wdata(init_wdata), .init_gnt(init_gnt),
    .init_rvalid(init_rvalid), .init_rdata(init_rdata), .init_err(init_err),
    .tgt_req(tgt_req), .tgt_addr(tgt_addr), .tgt_we(tgt_we), .tgt_be(tgt_be),
    .tgt_wdata(tgt_wdata), .tgt_gnt(tgt_gnt), .tgt_rvalid(tgt_rvalid),
    .tgt_rdata(tgt_rdata), .tgt_err(tgt_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // {init_gnt, tgt_addr, tgt_we, tgt_be, tgt_wdata, tgt_req}
  typedef logic [71:0] gnt_rec_t;
  // {init_rvalid, init_rdata, init_err}
  typedef logic [34:0] rsp_rec_t;

  gnt_rec_t gq[$];
  rsp_rec_t rq[$];

  int       m_phase = PH_FREE;
  int       m_owner = 0;
  int       m_last  = 1;
  int       m_cnt   = 0;
  gnt_rec_t m_pending;
  logic [1:0] gnt_seen = 2'b00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Reference model: decides at each cycle what the arbiter must present.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      m_phase = PH_FREE;
      m_last  = 1;
      m_cnt   = 0;
      gq.delete();
      rq.delete();
    end else begin
      case (m_phase)
        PH_FREE: begin
          if (init_req != 2'b00) begin
            if (init_req == 2'b11) m_owner = 1 - m_last;
            else                   m_owner = init_req[1] ? 1 : 0;
            m_pending = {onehot(m_owner), init_addr[m_owner*AW +: AW], init_we[m_owner],
                         init_be[m_owner*BW +: BW], init_wdata[m_owner*DW +: DW], 1'b1};
            m_phase = PH_ADDR;
          end
        end
        PH_ADDR: begin
          if (!init_req[m_owner]) begin
            m_phase = PH_FREE;
          end else if (tgt_gnt) begin
            gq.push_back(m_pending);
            m_last  = m_owner;
            m_cnt   = 0;
            m_phase = PH_RESP;
          end
        end
        PH_RESP: begin
          if (tgt_rvalid) begin
            rq.push_back({onehot(m_owner), tgt_rdata, tgt_err});
            m_phase = PH_FREE;
          end
`ifdef OBI_ARB_TIMEOUT_EN
          else if (m_cnt == TMO) begin
            rq.push_back({onehot(m_owner), 32'h0, 1'b1});
            m_phase = PH_FREE;
          end else begin
            m_cnt++;
          end
`endif
        end
        default: m_phase = PH_FREE;
      endcase
    end
  end

  // Monitor: compares every presented grant/response against the queues.
  initial forever begin
    @(negedge clk);
    #1;
    if (reset_n) begin
      gnt_seen = init_gnt;
      if (init_gnt != 2'b00 || gq.size() != 0)
        chk("grant", {init_gnt, tgt_addr, tgt_we, tgt_be, tgt_wdata, tgt_req},
            (gq.size() != 0) ? gq.pop_front() : gnt_rec_t'(0));
      if (init_rvalid != 2'b00 || rq.size() != 0)
        chk("response", {init_rvalid, init_rdata, init_err},
            (rq.size() != 0) ? rq.pop_front() : rsp_rec_t'(0));
      else
        chk("rdata_quiet", {init_rdata, init_err}, 0);
    end else begin
      gnt_seen = 2'b00;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_req   = 2'b00;
    tgt_gnt    = 1'b0;
    tgt_rvalid = 1'b0;
    tgt_rdata  = '0;
    tgt_err    = 1'b0;
  endtask

  task automatic set_init(input int i, input logic [AW-1:0] a, input logic we,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd);
    init_req[i]            = 1'b1;
    init_addr[i*AW +: AW]  = a;
    init_we[i]             = we;
    init_be[i*BW +: BW]    = be;
    init_wdata[i*DW +: DW] = wd;
  endtask

  task automatic tgt_auto();
    tgt_gnt    = 1'b1;
    tgt_rvalid = (m_phase == PH_RESP);
    tgt_rdata  = $urandom;
    tgt_err    = 1'b0;
  endtask

  task automatic rand_cycle(input bit drain);
    for (int i = 0; i < 2; i++) begin
      if (!init_req[i] || gnt_seen[i]) begin
        if (!drain && $urandom_range(99) < 40)
          set_init(i, $urandom, 1'($urandom_range(1)), 4'($urandom), $urandom);
        else
          init_req[i] = 1'b0;
      end
    end
    tgt_gnt    = ($urandom_range(99) < 60);
    tgt_rvalid = (m_phase == PH_RESP) ? ($urandom_range(99) < 40) : ($urandom_range(99) < 10);
    tgt_rdata  = $urandom;
    tgt_err    = 1'($urandom_range(1));
  endtask

  int        order[$];
  logic [7:0] got_order;
  int        k;

  initial begin
    reset_n    = 1'b0;
    init_addr  = '0;
    init_we    = '0;
    init_be    = '0;
    init_wdata = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {tgt_req, tgt_addr, tgt_we, tgt_be, tgt_wdata, init_gnt,
                        init_rvalid, init_rdata, init_err}, 0);
    reset_n = 1'b1;
    step();
    step();

    // Single read from initiator 0: grant at cycle 1, response at cycle 2.
    step(); set_init(0, 32'h0103_0100, 1'b0, 4'hF, 32'h0); tgt_gnt = 1'b1;
    #3 chk("lat_c0_idle", {init_gnt, tgt_req}, 0);
    step();
    #3 chk("lat_c1_grant", {init_gnt, tgt_req, tgt_addr}, {2'b01, 1'b1, 32'h0103_0100});
    step(); init_req = 2'b00; tgt_gnt = 1'b0; tgt_rvalid = 1'b1; tgt_rdata = 32'hA5A5_0001;
    #3 chk("lat_c2_resp", {init_rvalid, init_rdata, init_err}, {2'b01, 32'hA5A5_0001, 1'b0});
    step(); idle_inputs();

    // Target stalls the grant for five cycles.
    step(); set_init(0, 32'hDEAD_BEE0, 1'b0, 4'hF, 32'h0); tgt_gnt = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      #3 chk("stall_addr", {init_gnt, tgt_req, tgt_addr}, {2'b00, 1'b1, 32'hDEAD_BEE0});
    end
    step(); tgt_gnt = 1'b1;
    #3 chk("stall_release", init_gnt, 2'b01);
    step(); init_req = 2'b00; tgt_gnt = 1'b0; tgt_rvalid = 1'b1; tgt_rdata = 32'h0BAD_F00D;
    step(); idle_inputs();

    // Write from initiator 1 answered with an error.
    step(); set_init(1, 32'h0000_0040, 1'b1, 4'b0011, 32'h1234_5678); tgt_gnt = 1'b1;
    step();
    #3 chk("wr_achan", {init_gnt, tgt_we, tgt_be, tgt_wdata}, {2'b10, 1'b1, 4'b0011, 32'h1234_5678});
    step(); init_req = 2'b00; tgt_gnt = 1'b0; tgt_rvalid = 1'b1; tgt_rdata = 32'h0; tgt_err = 1'b1;
    #3 chk("wr_err_resp", {init_rvalid, init_err}, {2'b10, 1'b1});
    step(); idle_inputs();

    // Silent target during the response phase.
    step(); set_init(0, 32'h0000_0200, 1'b0, 4'hF, 32'h0); tgt_gnt = 1'b1;
    step();
    step(); init_req = 2'b00; tgt_gnt = 1'b0;
`ifdef OBI_ARB_TIMEOUT_EN
    #3 chk("tmo_wait", init_rvalid, 2'b00);
    for (int c = 0; c < 3; c++) begin
      step();
      #3 chk("tmo_wait", init_rvalid, 2'b00);
    end
    step();
    #3 chk("tmo_resp", {init_rvalid, init_rdata, init_err}, {2'b01, 32'h0, 1'b1});
    step(); tgt_rvalid = 1'b1; tgt_rdata = 32'hFFFF_FFFF;
    #3 chk("tmo_late_dropped", init_rvalid, 2'b00);
`else
    #3 chk("resp_wait", init_rvalid, 2'b00);
    for (int c = 0; c < 11; c++) begin
      step();
      #3 chk("resp_wait", init_rvalid, 2'b00);
    end
    step(); tgt_rvalid = 1'b1; tgt_rdata = 32'h0000_600D;
    #3 chk("resp_after_wait", {init_rvalid, init_rdata, init_err}, {2'b01, 32'h0000_600D, 1'b0});
`endif
    step(); idle_inputs();

    // Reset during RESP, then a tie and continuous round-robin.
    step(); set_init(1, 32'h0000_0300, 1'b0, 4'hF, 32'h0); tgt_gnt = 1'b1;
    step();
    step(); tgt_gnt = 1'b0;
    set_init(0, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
    set_init(1, 32'h0000_2000, 1'b1, 4'hC, 32'h5555_AAAA);
    tgt_rvalid = 1'b1; tgt_rdata = 32'h0000_CAFE;
    #1 reset_n = 1'b0;
    #1 chk("reset_async", {tgt_req, tgt_addr, tgt_we, tgt_be, tgt_wdata, init_gnt,
                           init_rvalid, init_rdata, init_err}, 0);
    step();
    step();
    reset_n = 1'b1; tgt_gnt = 1'b1; tgt_rvalid = 1'b1;
    #3 chk("late_rvalid_after_reset", init_rvalid, 2'b00);
    order.delete();
    for (int c = 0; c < 20; c++) begin
      step(); tgt_auto();
      #3;
      if (init_gnt == 2'b01) order.push_back(0);
      else if (init_gnt == 2'b10) order.push_back(1);
      if (order.size() == 4) break;
    end
    got_order = 8'hFF;
    for (int i = 0; i < 4; i++)
      got_order = {got_order[5:0], (i < order.size()) ? 2'(order[i]) : 2'b11};
    chk("rr_order", got_order, 8'b00_01_00_01);
    for (int c = 0; c < 4; c++) begin
      step(); init_req = 2'b00; tgt_auto();
    end
    step(); idle_inputs();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step(); rand_cycle(1'b0);
    end
    k = 0;
    while (k < 300 && !(m_phase == PH_FREE && init_req == 2'b00)) begin
      step(); rand_cycle(1'b1);
      k++;
    end
    chk("drain_done", (k < 300), 1);
    step(); idle_inputs();
    step();
    step();
    chk("scoreboard_empty", gq.size() + rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
